// File: rtl/blit_sched_pkg.sv
// Shared types and constants for the blitter scheduler: FSM states,
// requester indices and stop-register data bit positions.
package blit_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        STOPPED = 3'd3,
        RECOVER = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int REQ_GPU = 0;
    localparam int REQ_DSP = 1;

    localparam int STOP_RESUME_BIT = 0;
    localparam int STOP_ABORT_BIT  = 1;

    function automatic logic [1:0] onehot(input logic idx);
        onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/blit_sched_rr_arb.sv
// Two-input round-robin picker: on a tie the requester that did not own
// the blitter last wins; a lone requester always wins.
module blit_rr_arb
    import blit_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else begin
            winner = req[REQ_DSP];
        end
    end

endmodule

// File: rtl/blit_sched.sv
// Blitter scheduler: arbitrates GPU/DSP jobs, sequences start/run/done and
// forwards the owner's resume/abort decision after a collision stop.
// Build option STOP_TIMEOUT_EN adds an automatic abort after TIMEOUT stopped cycles.
// Handshake: req is a level held by the requester; gnt answers one cycle later and
// stays high through the done pulse; resume/abort are single-cycle strobes from the owner.
module blit_sched
    import blit_sched_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 10,
    parameter int CW      = 8
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          done_abort,
    output logic          owner,
    output logic          blit_start,
    input  logic          blit_busy,
    input  logic          blit_stopped,
    output logic [1:0]    coll_irq,
    input  logic [1:0]    resume,
    input  logic [1:0]    abort,
    output logic          stop_ld,
    output logic          stop_resume,
    output logic          stop_abort,
    output logic [CW-1:0] coll_count,
    output state_t        dbg_state
);

    if (TIMEOUT > (2 ** TW)) begin : g_tw_check
        $error("TW too narrow for TIMEOUT");
    end

    state_t     state;
    logic       last_owner;
    logic       seen_busy;
    logic       aborted;
    logic [1:0] stop_data;
    logic       arb_valid;
    logic       arb_winner;
    logic       own_resume;
    logic       own_abort;
    logic       do_abort;

    blit_rr_arb u_arb (
        .req        (req),
        .last_owner (last_owner),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign dbg_state   = state;
    assign stop_resume = stop_data[STOP_RESUME_BIT];
    assign stop_abort  = stop_data[STOP_ABORT_BIT];
    assign own_resume  = resume[owner];
    assign own_abort   = abort[owner];

`ifdef STOP_TIMEOUT_EN
    logic [TW-1:0] stop_cnt;
    // An owner resume in the expiry cycle still beats the automatic abort.
    assign do_abort = own_abort | ((stop_cnt == TW'(TIMEOUT - 1)) & ~own_resume);
`else
    assign do_abort = own_abort;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            seen_busy  <= 1'b0;
            aborted    <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            done_abort <= 1'b0;
            owner      <= 1'b0;
            blit_start <= 1'b0;
            coll_irq   <= '0;
            stop_ld    <= 1'b0;
            stop_data  <= '0;
            coll_count <= '0;
`ifdef STOP_TIMEOUT_EN
            stop_cnt   <= '0;
`endif
        end else begin
            blit_start <= 1'b0;
            done       <= '0;
            done_abort <= 1'b0;
            stop_ld    <= 1'b0;
            stop_data  <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        owner <= arb_winner;
                        gnt   <= onehot(arb_winner);
                        state <= START;
                    end
                end
                START: begin
                    blit_start <= 1'b1;
                    seen_busy  <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    if (blit_busy) seen_busy <= 1'b1;
                    if (blit_stopped) begin
                        coll_irq <= onehot(owner);
                        if (coll_count != '1) coll_count <= coll_count + 1'b1;
`ifdef STOP_TIMEOUT_EN
                        stop_cnt <= '0;
`endif
                        state    <= STOPPED;
                    end else if (seen_busy && !blit_busy) begin
                        done       <= onehot(owner);
                        done_abort <= aborted;
                        state      <= DONE;
                    end
                end
                STOPPED: begin
`ifdef STOP_TIMEOUT_EN
                    stop_cnt <= stop_cnt + 1'b1;
`endif
                    if (do_abort) begin
                        stop_ld                   <= 1'b1;
                        stop_data[STOP_ABORT_BIT] <= 1'b1;
                        aborted                   <= 1'b1;
                        coll_irq                  <= '0;
                        state                     <= RECOVER;
                    end else if (own_resume) begin
                        stop_ld                    <= 1'b1;
                        stop_data[STOP_RESUME_BIT] <= 1'b1;
                        coll_irq                   <= '0;
                        state                      <= RECOVER;
                    end
                end
                RECOVER: begin
                    // seen_busy is kept so a resumed job may finish without a fresh busy rise.
                    if (!blit_stopped) begin
                        if (aborted) begin
                            done       <= onehot(owner);
                            done_abort <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    gnt        <= '0;
                    last_owner <= owner;
                    aborted    <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
